// File: rtl/div_issue_ctrl_if.sv
// rtl/div_issue_ctrl_if.sv - decode, divider and writeback signal bundle for div_issue_ctrl
//
// Purpose: groups every handshake/bus signal of the divide issue controller.
// Modports:
//   master - the controller: consumes decode/divider/writeback inputs, drives
//            dec_ready, div_start/cmd/op1/op2, wb_valid/rd/data, busy, perf_div_cycles
//   slave  - the surrounding pipeline and divider (mirror image of master)
// Signals:
//   dec_valid/dec_ready/dec_cmd/dec_op1/dec_op2/dec_rd  decode request
//   flush                                               pipeline kill
//   div_start/div_cmd/div_op1/div_op2                   divider launch
//   div_done/div_busy/div_res                           divider status/result
//   wb_valid/wb_ready/wb_rd/wb_data                     writeback port
//   busy/perf_div_cycles                                status and busy-cycle counter
interface div_issue_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             dec_valid;
  logic             dec_ready;
  logic [1:0]       dec_cmd;
  logic [XLEN-1:0]  dec_op1;
  logic [XLEN-1:0]  dec_op2;
  logic [4:0]       dec_rd;
  logic             flush;
  logic             div_start;
  logic [1:0]       div_cmd;
  logic [XLEN-1:0]  div_op1;
  logic [XLEN-1:0]  div_op2;
  logic             div_done;
  logic             div_busy;
  logic [XLEN-1:0]  div_res;
  logic             wb_valid;
  logic             wb_ready;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             busy;
  logic [CNT_W-1:0] perf_div_cycles;

  modport master (
    input  dec_valid, dec_cmd, dec_op1, dec_op2, dec_rd, flush,
    input  div_done, div_busy, div_res, wb_ready,
    output dec_ready, div_start, div_cmd, div_op1, div_op2,
    output wb_valid, wb_rd, wb_data, busy, perf_div_cycles
  );

  modport slave (
    output dec_valid, dec_cmd, dec_op1, dec_op2, dec_rd, flush,
    output div_done, div_busy, div_res, wb_ready,
    input  dec_ready, div_start, div_cmd, div_op1, div_op2,
    input  wb_valid, wb_rd, wb_data, busy, perf_div_cycles
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - EXE-stage sequencer in front of the iterative RV32M divider
//
// Purpose: accepts one divide/remainder op from decode, launches the divider
// with a one-cycle start pulse, waits for completion and presents the result
// on a valid/ready writeback port. A flushed op cannot abort the divider, so
// it is drained and its result dropped.
// Optional feature: define DIV_RESULT_REUSE_EN to add a 1-entry result cache;
// an accepted op matching the cached {cmd, op1, op2} goes straight to HOLD.
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset (shared with the divider)
//   bus      div_issue_ctrl_if.master: decode, flush, divider and writeback signals
module div_issue_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input logic              clk,
  input logic              reset_n,
  div_issue_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t           r_state;
  logic [1:0]       r_cmd;
  logic [XLEN-1:0]  r_op1;
  logic [XLEN-1:0]  r_op2;
  logic [4:0]       r_rd;
  logic [4:0]       r_wb_rd;
  logic [XLEN-1:0]  r_wb_data;
  logic [CNT_W-1:0] r_perf;

  logic             w_dec_ready;
  logic             w_accept;
  logic             w_start;
  logic             w_hit;
  logic [XLEN-1:0]  w_hit_res;

  // Gating with reset_n keeps dec_ready low for as long as reset is held.
  assign w_dec_ready = reset_n & (r_state == S_IDLE) & ~bus.flush;
  assign w_accept    = bus.dec_valid & w_dec_ready;
  // A drained op may leave the divider busy; never start on top of it.
  assign w_start     = (r_state == S_LAUNCH) & ~bus.flush & ~bus.div_busy;

`ifdef DIV_RESULT_REUSE_EN
  logic             r_c_valid;
  logic [1:0]       r_c_cmd;
  logic [XLEN-1:0]  r_c_op1;
  logic [XLEN-1:0]  r_c_op2;
  logic [XLEN-1:0]  r_c_res;

  assign w_hit     = r_c_valid & (r_c_cmd == bus.dec_cmd) &
                     (r_c_op1 == bus.dec_op1) & (r_c_op2 == bus.dec_op2);
  assign w_hit_res = r_c_res;

  // Only results that reach HOLD are cached; flushed or drained ones never are.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_c_valid <= 1'b0;
      r_c_cmd   <= '0;
      r_c_op1   <= '0;
      r_c_op2   <= '0;
      r_c_res   <= '0;
    end else if (r_state == S_WAIT && bus.div_done && !bus.flush) begin
      r_c_valid <= 1'b1;
      r_c_cmd   <= r_cmd;
      r_c_op1   <= r_op1;
      r_c_op2   <= r_op2;
      r_c_res   <= bus.div_res;
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_hit_res = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cmd     <= '0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_rd      <= '0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cmd <= bus.dec_cmd;
            r_op1 <= bus.dec_op1;
            r_op2 <= bus.dec_op2;
            r_rd  <= bus.dec_rd;
            if (w_hit) begin
              r_wb_data <= w_hit_res;
              r_wb_rd   <= bus.dec_rd;
              r_state   <= S_HOLD;
            end else begin
              r_state <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          if (bus.flush)         r_state <= S_IDLE;
          else if (!bus.div_busy) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.div_done) begin
            // flush in the completion cycle simply discards the result
            if (bus.flush) begin
              r_state <= S_IDLE;
            end else begin
              r_wb_data <= bus.div_res;
              r_wb_rd   <= r_rd;
              r_state   <= S_HOLD;
            end
          end else if (bus.flush) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (bus.div_done) r_state <= S_IDLE;
        end
        S_HOLD: begin
          if (bus.flush || bus.wb_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf <= '0;
    end else if (r_state != S_IDLE && r_perf != '1) begin
      r_perf <= r_perf + CNT_W'(1);
    end
  end

  assign bus.dec_ready       = w_dec_ready;
  assign bus.div_start       = w_start;
  assign bus.div_cmd         = r_cmd;
  assign bus.div_op1         = r_op1;
  assign bus.div_op2         = r_op2;
  assign bus.wb_valid        = (r_state == S_HOLD);
  assign bus.wb_rd           = r_wb_rd;
  assign bus.wb_data         = r_wb_data;
  assign bus.busy            = (r_state != S_IDLE);
  assign bus.perf_div_cycles = r_perf;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - scoreboard bench for div_issue_ctrl with a behavioural divider
module tb_div_issue_ctrl;
  localparam int XLEN  = 32;
  localparam int CNT_W = 6;
  localparam int PERF_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  div_issue_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  div_issue_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // RV32M result rules, including divide-by-zero and signed overflow.
  function automatic logic [31:0] ref_div(input logic [1:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (cmd)
      2'b00:   return (b == 0) ? a : a % b;
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : (ovf ? 32'h0 : 32'($signed(a) % $signed(b)));
    endcase
  endfunction

  // Behavioural divider: random latency, done for one cycle, optional busy tail.
  initial begin
    bit          st_go;
    logic [1:0]  st_cmd;
    logic [31:0] st_a, st_b;
    int          st_cnt, st_tail;
    st_cnt = 0; st_tail = 0; st_cmd = 0; st_a = 0; st_b = 0;
    bus.div_done = 1'b0;
    bus.div_busy = 1'b0;
    bus.div_res  = '0;
    forever begin
      @(negedge clk);
      st_go = reset_n && bus.div_start;
      if (st_go) begin
        st_cmd = bus.div_cmd; st_a = bus.div_op1; st_b = bus.div_op2;
      end
      @(posedge clk); #1;
      if (!reset_n) begin
        st_cnt = 0; st_tail = 0;
        bus.div_done = 1'b0; bus.div_busy = 1'b0; bus.div_res = '0;
      end else if (st_go) begin
        bus.div_busy = 1'b1; bus.div_done = 1'b0;
        st_cnt  = $urandom_range(3, 10);
        st_tail = $urandom_range(0, 2);
      end else if (st_cnt > 0) begin
        st_cnt--;
        if (st_cnt == 0) begin
          bus.div_done = 1'b1;
          bus.div_res  = ref_div(st_cmd, st_a, st_b);
        end
      end else begin
        bus.div_done = 1'b0;
        bus.div_res  = $urandom;
        if (st_tail > 0) begin st_tail--; bus.div_busy = 1'b1; end
        else bus.div_busy = 1'b0;
      end
    end
  end

  // Monitor: abstract op-lifecycle model plus scoreboard pop on writeback handshake.
  initial begin
    bit          live, started, have_res, drain, prev_wv;
    bit          idle_m, exp_s, hs, hit;
    logic [1:0]  m_cmd;
    logic [31:0] m_a, m_b, prev_data;
    logic [4:0]  prev_rd;
    int          perf_m;
    bit          c_v;
    logic [1:0]  c_cmd;
    logic [31:0] c_a, c_b;
    exp_t        e;
    live = 0; started = 0; have_res = 0; drain = 0; prev_wv = 0; perf_m = 0;
    c_v = 0; c_cmd = 0; c_a = 0; c_b = 0; m_cmd = 0; m_a = 0; m_b = 0;
    prev_data = 0; prev_rd = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        live = 0; started = 0; have_res = 0; drain = 0; prev_wv = 0; perf_m = 0; c_v = 0;
      end else begin
        idle_m = !live && !drain;
        chk("dec_ready", 64'(bus.dec_ready), 64'(idle_m && !bus.flush));
        chk("busy", 64'(bus.busy), 64'(!idle_m));
        chk("wb_valid", 64'(bus.wb_valid), 64'(have_res));
        exp_s = live && !started && !have_res && !bus.flush && !bus.div_busy;
        chk("div_start", 64'(bus.div_start), 64'(exp_s));
        chk("perf", 64'(bus.perf_div_cycles), 64'(perf_m));
        if (prev_wv && bus.wb_valid)
          chk("wb_stable", {27'd0, bus.wb_rd, bus.wb_data}, {27'd0, prev_rd, prev_data});
        hs = bus.wb_valid && bus.wb_ready && !bus.flush;
        if (hs) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL wb_unexpected actual rd=%0d data=%0h required=none", bus.wb_rd, bus.wb_data);
          end else begin
            e = exp_q.pop_front();
            chk("wb_result", {27'd0, bus.wb_rd, bus.wb_data}, {27'd0, e.rd, e.data});
          end
        end
        prev_wv = bus.wb_valid && !hs && !bus.flush;
        prev_rd = bus.wb_rd; prev_data = bus.wb_data;

        if (!idle_m && perf_m < PERF_MAX) perf_m++;
        if (drain && bus.div_done) drain = 0;
        if (bus.div_start && live) started = 1;
        if (live) begin
          if (bus.flush) begin
            if (started && !have_res && !bus.div_done) drain = 1;
            live = 0; started = 0; have_res = 0;
          end else if (have_res) begin
            if (hs) begin live = 0; started = 0; have_res = 0; end
          end else if (started && bus.div_done) begin
            have_res = 1;
            c_v = 1; c_cmd = m_cmd; c_a = m_a; c_b = m_b;
          end
        end
        if (idle_m && !bus.flush && bus.dec_valid) begin
          hit = 0;
`ifdef DIV_RESULT_REUSE_EN
          hit = c_v && (c_cmd == bus.dec_cmd) && (c_a == bus.dec_op1) && (c_b == bus.dec_op2);
`endif
          live = 1; started = 0; have_res = hit;
          m_cmd = bus.dec_cmd; m_a = bus.dec_op1; m_b = bus.dec_op2;
        end
      end
    end
  end

  // fl: 0 = normal writeback, >0 = flush that many cycles after accept, <0 = reset mid-WAIT
  task automatic run_op(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int fl, input int hold);
    int n;
    bit ok;
    @(posedge clk); #1;
    bus.dec_valid = 1'b1; bus.dec_cmd = cmd; bus.dec_op1 = a; bus.dec_op2 = b; bus.dec_rd = rd;
    bus.wb_ready = (fl == 0 && hold == 0);
    n = 0; ok = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (bus.dec_ready) ok = 1;
      else begin n++; @(posedge clk); #1; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
      bus.dec_valid = 1'b0; bus.wb_ready = 1'b0;
      return;
    end
    if (fl == 0) exp_q.push_back('{rd: rd, data: ref_div(cmd, a, b)});
    @(posedge clk); #1;
    bus.dec_valid = 1'b0; bus.dec_cmd = 2'($urandom); bus.dec_op1 = $urandom; bus.dec_op2 = $urandom;
    bus.dec_rd = 5'($urandom);
    if (fl > 0) begin
      repeat (fl - 1) begin @(posedge clk); #1; end
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
    end else if (fl < 0) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.div_start && n < 50);
      repeat (2) begin @(posedge clk); #1; end
      reset_n = 1'b0;
      #1;
      chk("rst_dec_ready", 64'(bus.dec_ready), 64'd0);
      chk("rst_div_start", 64'(bus.div_start), 64'd0);
      chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_wb_rd", 64'(bus.wb_rd), 64'd0);
      chk("rst_wb_data", 64'(bus.wb_data), 64'd0);
      chk("rst_perf", 64'(bus.perf_div_cycles), 64'd0);
      chk("rst_div_op1", 64'(bus.div_op1), 64'd0);
      repeat (2) begin @(posedge clk); #1; end
      reset_n = 1'b1;
    end else begin
      if (hold > 0) begin
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.wb_valid && n < 100);
        repeat (hold) begin @(posedge clk); #1; end
        bus.wb_ready = 1'b1;
      end
      n = 0;
      do begin @(negedge clk); n++; end while (!(bus.wb_valid && bus.wb_ready) && n < 100);
      if (n >= 100) begin
        checks++; failures++;
        $display("FAIL wb_timeout actual=no_handshake required=handshake");
      end
      @(posedge clk); #1;
      bus.wb_ready = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [1:0]  cmd;
    logic [31:0] a, b;
    bus.dec_valid = 1'b0; bus.dec_cmd = '0; bus.dec_op1 = '0; bus.dec_op2 = '0; bus.dec_rd = '0;
    bus.flush = 1'b0; bus.wb_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_dec_ready", 64'(bus.dec_ready), 64'd0);
    chk("init_busy", 64'(bus.busy), 64'd0);
    chk("init_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("init_div_start", 64'(bus.div_start), 64'd0);
    chk("init_wb_data", 64'(bus.wb_data), 64'd0);
    chk("init_perf", 64'(bus.perf_div_cycles), 64'd0);
    reset_n = 1'b1;

    run_op(2'b10, 32'd100, 32'd7, 5'd5, 0, 0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, 5);
    run_op(2'b01, 32'h1234, 32'd0, 5'd7, 0, 1);
    run_op(2'b10, 32'd100, 32'd7, 5'd8, 0, 0);
    run_op(2'b01, 32'd100, 32'd7, 5'd9, 0, 2);
    run_op(2'b10, 32'd55, 32'd3, 5'd10, 6, 0);
    run_op(2'b10, 32'd100, 32'd10, 5'd11, 0, 0);
    run_op(2'b00, 32'd77, 32'd5, 5'd12, 1, 0);
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, 0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0, 3);

    cmd = 2'b10; a = 32'd9; b = 32'd4;
    for (int i = 0; i < 60; i++) begin
      if ($urandom % 10 >= 3) begin
        cmd = 2'($urandom); a = rand_val(); b = rand_val();
      end
      run_op(cmd, a, b, 5'($urandom), ($urandom % 4 == 0) ? $urandom_range(1, 9) : 0,
             $urandom_range(0, 3));
    end

    run_op(2'b10, 32'd100, 32'd7, 5'd3, 0, 0);
    run_op(2'b10, 32'h00AB_CDEF, 32'd3, 5'd4, -1, 0);
    run_op(2'b10, 32'd100, 32'd7, 5'd5, 0, 0);
    run_op(2'b11, 32'd17, 32'd0, 5'd6, 0, 2);

    repeat (20) @(posedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
